boe_sched: RTL and testbench

- Two-requester scheduler that shares one batch statistics engine (sum / min / descending-sort unit) between clients.
- Arbitrates batch requests round-robin, streams the winner's samples into the engine, and waits the engine's fixed latency.
- Captures the engine's result stream (sum, min, then sorted values) and returns it tagged with the owner's ID.
- Sits between client front-ends and the single engine instance.

---
 rtl/boe_sched_if.sv | 58 +++++
 rtl/boe_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_boe_sched.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boe_sched_if.sv
// ----------------------------------------------------------------------------
// boe_sched_if
//
// Bundles every client-side and engine-side signal of the boe_sched scheduler.
//
// Handshake semantics (no backpressure anywhere):
//   * req[i] is a request level. The requester holds it (with len_i stable)
//     until it sees gnt[i]. The scheduler answers either with gnt[i] for
//     exactly len_i consecutive cycles, or with a one-cycle err[i] pulse when
//     len_i is illegal.
//   * While gnt[i] is high the requester presents one new sample on din_i
//     every cycle. The sample is accepted in every grant cycle.
//   * res_valid qualifies res_data/res_id/res_last for exactly one cycle per
//     word. The consumer must always accept it.
//
// Modports:
//   slave  - the scheduler (boe_sched)
//   master - the environment: client front-ends plus the statistics engine,
//            which is why eng_result is driven from this side
//
// Parameters: DW sample width, RW engine result width.
// ----------------------------------------------------------------------------
interface boe_sched_if #(
    parameter int DW = 8,
    parameter int RW = 11
);
    // client requests and samples
    logic [1:0]    req;
    logic [2:0]    len0;
    logic [2:0]    len1;
    logic [DW-1:0] din0;
    logic [DW-1:0] din1;
    // client answers
    logic [1:0]    gnt;
    logic [1:0]    err;
    // engine side
    logic [2:0]    eng_num;
    logic [DW-1:0] eng_data;
    logic [RW-1:0] eng_result;
    // tagged result stream
    logic          res_valid;
    logic          res_id;
    logic          res_last;
    logic [RW-1:0] res_data;
    logic          busy;

    modport slave (
        input  req, len0, len1, din0, din1, eng_result,
        output gnt, err, eng_num, eng_data,
        output res_valid, res_id, res_last, res_data, busy
    );

    modport master (
        output req, len0, len1, din0, din1, eng_result,
        input  gnt, err, eng_num, eng_data,
        input  res_valid, res_id, res_last, res_data, busy
    );
endinterface

// File: rtl/boe_sched.sv
// ----------------------------------------------------------------------------
// boe_sched
//
// Two-requester scheduler in front of a single batch statistics engine
// (sum / min / descending sort). A winning requester streams its batch of
// n samples into the engine, the scheduler waits the engine's fixed latency,
// then captures the n+2 result words (sum, min, n sorted values) and returns
// them tagged with the owner's ID.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (discards any batch in flight)
//   bus        boe_sched_if.slave: req/len0/len1/din0/din1 from clients,
//              gnt/err back to them, eng_num/eng_data to the engine,
//              eng_result from it, res_valid/res_id/res_last/res_data out,
//              busy high whenever the FSM is not IDLE
//   dbg_state  current FSM state (IDLE=0, LOAD=1, WAIT=2, DRAIN=3)
//
// Parameters:
//   DW       sample width
//   RW       engine result width
//   MAXN     largest legal batch length (must fit the 3-bit len fields)
//   RES_LAT  cycles the FSM spends in WAIT between LOAD and DRAIN (1..7)
//
// Build option:
//   BOE_SCHED_PRIO_EN  when defined, requester 0 always wins a simultaneous
//                      request (fixed priority); otherwise round-robin.
//                      Illegal-length rejection is the same in both builds.
//
// Timing, counting the req-sampling edge as cycle 0:
//   gnt                 cycles 1 .. n
//   first res_valid     cycle  n + RES_LAT + 2
//   res_last            cycle  2n + RES_LAT + 3 (first IDLE cycle, where a
//                       new arbitration may already take place)
// ----------------------------------------------------------------------------
module boe_sched #(
    parameter int DW      = 8,
    parameter int RW      = 11,
    parameter int MAXN    = 6,
    parameter int RES_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    boe_sched_if.slave  bus,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] MAXN_L   = 3'(MAXN);
    // WAIT lasts RES_LAT cycles, counted 0 .. RES_LAT-1
    localparam logic [3:0] LAT_LAST = 4'(RES_LAT - 1);

    // ------------------------------------------------------------------
    // state
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;        // round-robin pointer
    logic          owner_q, owner_d;    // requester owning the batch
    logic [2:0]    n_q, n_d;            // batch length
    // 4 bits: DRAIN counts up to n+1 = 7 at most, LOAD/WAIT stay below 8
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    err_q, err_d;
    logic          res_valid_q, res_valid_d;
    logic          res_id_q, res_id_d;
    logic          res_last_q, res_last_d;
    logic [RW-1:0] res_data_q, res_data_d;

    // ------------------------------------------------------------------
    // arbitration
    // ------------------------------------------------------------------
    logic       win;        // winning requester (meaningful only if |req)
    logic [2:0] win_len;
    logic       len_ok;

`ifdef BOE_SCHED_PRIO_EN
    // fixed priority: requester 0 wins whenever it asks
    assign win = ~bus.req[0];
`else
    // round-robin: the pointer holder wins if it asks, else the other one
    assign win = bus.req[ptr_q] ? ptr_q : ~ptr_q;
`endif

    assign win_len = win ? bus.len1 : bus.len0;
    assign len_ok  = (win_len != 3'd0) && (win_len <= MAXN_L);

    // ------------------------------------------------------------------
    // state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            n_q         <= 3'd0;
            cnt_q       <= 4'd0;
            err_q       <= 2'b00;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_last_q  <= res_last_d;
            res_data_q  <= res_data_d;
        end
    end

    // ------------------------------------------------------------------
    // next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        err_d       = 2'b00;
        res_valid_d = 1'b0;
        res_id_d    = 1'b0;
        res_last_d  = 1'b0;
        res_data_d  = res_data_q;   // hold the last word between bursts

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    n_d = win_len;
                    if (len_ok) begin
                        state_d = LOAD;
                        owner_d = win;
                        cnt_d   = 4'd0;
                    end else begin
                        // reject: pulse err and hand the turn to the other side
                        err_d = win ? 2'b10 : 2'b01;
                        ptr_d = ~ptr_q;
                    end
                end
            end

            LOAD: begin
                // exactly n samples, regardless of what req does meanwhile
                if (cnt_q == {1'b0, n_q - 3'd1}) begin
                    state_d = WAIT;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            DRAIN: begin
                // capture one engine word per cycle; it appears registered
                // on res_data the following cycle
                res_valid_d = 1'b1;
                res_id_d    = owner_q;
                res_data_d  = bus.eng_result;
                if (cnt_q == ({1'b0, n_q} + 4'd1)) begin
                    res_last_d = 1'b1;
                    ptr_d      = ~owner_q;
                    state_d    = IDLE;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // LOAD-phase outputs: grant and sample forwarding are combinational so
    // the engine sees din in the same cycle the requester drives it
    // ------------------------------------------------------------------
    logic [1:0]    gnt_c;
    logic [2:0]    eng_num_c;
    logic [DW-1:0] eng_data_c;

    always_comb begin
        gnt_c      = 2'b00;
        eng_num_c  = 3'd0;
        eng_data_c = '0;
        if (state_q == LOAD) begin
            gnt_c      = owner_q ? 2'b10 : 2'b01;
            eng_num_c  = n_q;
            eng_data_c = owner_q ? bus.din1 : bus.din0;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.eng_num   = eng_num_c;
    assign bus.eng_data  = eng_data_c;
    assign bus.err       = err_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_last  = res_last_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = (state_q != IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_boe_sched.sv
// ----------------------------------------------------------------------------
// tb_boe_sched
//
// Directed bench for boe_sched. A stub engine computes sum / min / descending
// sort of whatever it is fed and replays the words RES_LAT cycles after the
// last sample. A feeder drives din0/din1 from per-test sample tables while the
// matching gnt bit is high. Expected result words are hand-computed constants.
// Outputs are observed 1 time unit after each rising clock edge.
// ----------------------------------------------------------------------------
module tb_boe_sched;

    localparam int DW      = 8;
    localparam int RW      = 11;
    localparam int RES_LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    int tests = 0;
    int fails = 0;

    boe_sched_if #(.DW(DW), .RW(RW)) bus ();

    boe_sched #(.DW(DW), .RW(RW), .MAXN(6), .RES_LAT(RES_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    logic [29:0] all_outs;
    assign all_outs = {bus.gnt, bus.err, bus.eng_num, bus.eng_data, bus.res_valid,
                       bus.res_id, bus.res_last, bus.res_data, bus.busy};

    // ---------------- sample feeder ----------------
    logic [DW-1:0] din0_vals[6];
    logic [DW-1:0] din1_vals[6];
    int f0 = 0;
    int f1 = 0;

    always @(negedge clk) begin
        if (bus.gnt[0] === 1'b1) begin
            bus.din0 = din0_vals[f0 % 6];
            f0 = f0 + 1;
        end else begin
            bus.din0 = 8'hEE;
            f0 = 0;
        end
        if (bus.gnt[1] === 1'b1) begin
            bus.din1 = din1_vals[f1 % 6];
            f1 = f1 + 1;
        end else begin
            bus.din1 = 8'hDD;
            f1 = 0;
        end
    end

    // ---------------- stub engine ----------------
    logic [DW-1:0] s_buf[6];
    logic [DW-1:0] s_srt[6];
    logic [RW-1:0] s_words[8];
    logic [RW-1:0] s_sum;
    logic [DW-1:0] s_min;
    logic [DW-1:0] s_t;
    int s_idx, s_delay, s_pos, s_nw;

    always @(posedge clk) begin
        if (rst) begin
            s_idx = 0; s_delay = 0; s_pos = 0; s_nw = 0;
            bus.eng_result <= '0;
        end else begin
            if (s_pos > 0) begin
                if (s_pos < s_nw) begin
                    bus.eng_result <= s_words[s_pos];
                    s_pos = s_pos + 1;
                end else begin
                    bus.eng_result <= '0;
                    s_pos = 0;
                end
            end
            if (s_delay > 1) begin
                s_delay = s_delay - 1;
            end else if (s_delay == 1) begin
                bus.eng_result <= s_words[0];
                s_pos = 1;
                s_delay = 0;
            end
            if (bus.eng_num != 3'd0 && s_idx < 6) begin
                s_buf[s_idx] = bus.eng_data;
                s_idx = s_idx + 1;
                if (s_idx == int'(bus.eng_num)) begin
                    s_sum = '0;
                    s_min = '1;
                    for (int i = 0; i < s_idx; i++) begin
                        s_sum = s_sum + RW'(s_buf[i]);
                        if (s_buf[i] < s_min) s_min = s_buf[i];
                        s_srt[i] = s_buf[i];
                    end
                    for (int i = 0; i < s_idx; i++)
                        for (int j = 0; j < s_idx - 1 - i; j++)
                            if (s_srt[j] < s_srt[j+1]) begin
                                s_t = s_srt[j]; s_srt[j] = s_srt[j+1]; s_srt[j+1] = s_t;
                            end
                    s_words[0] = s_sum;
                    s_words[1] = RW'(s_min);
                    for (int i = 0; i < s_idx; i++) s_words[i+2] = RW'(s_srt[i]);
                    s_nw = s_idx + 2;
                    s_idx = 0;
                    s_delay = RES_LAT;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (bus.busy === 1'b1 && k < 60) begin
            tick();
            k++;
        end
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, bus.busy, k);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.req = 2'b11; bus.len0 = 3'd2; bus.len1 = 3'd2;
        tick();
        tick();
        tests++;
        if (all_outs !== 30'd0) begin
            fails++; $display("FAIL reset_hold: outputs=%h, required 0", all_outs);
        end
        rst = 1'b0;
        bus.req = 2'b00;
        tick();
        tests++;
        if (all_outs !== 30'd0) begin
            fails++; $display("FAIL reset_release: outputs=%h, required 0", all_outs);
        end
        tests++;
        if (dbg_state !== 2'd0) begin
            fails++; $display("FAIL reset_state: state=%0d, required 0", dbg_state);
        end
    endtask

    task automatic test_single_batch();
        logic [RW-1:0] exp_q[$];
        logic [RW-1:0] w;
        do_reset();
        din0_vals[0] = 8'd5; din0_vals[1] = 8'd9; din0_vals[2] = 8'd2;
        exp_q = '{11'd16, 11'd2, 11'd9, 11'd5, 11'd2};
        bus.len0 = 3'd3; bus.req = 2'b01;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) bus.req = 2'b00;
            tests++;
            if (bus.gnt !== ((c <= 3) ? 2'b01 : 2'b00)) begin
                fails++; $display("FAIL single_gnt c%0d: gnt=%b, required %b", c, bus.gnt, (c <= 3) ? 2'b01 : 2'b00);
            end
            tests++;
            if (bus.eng_num !== ((c <= 3) ? 3'd3 : 3'd0)) begin
                fails++; $display("FAIL single_eng_num c%0d: eng_num=%0d", c, bus.eng_num);
            end
            tests++;
            if (bus.res_valid !== (c >= 7 && c <= 11)) begin
                fails++; $display("FAIL single_valid c%0d: res_valid=%b", c, bus.res_valid);
            end
            tests++;
            if (bus.res_last !== (c == 11)) begin
                fails++; $display("FAIL single_last c%0d: res_last=%b", c, bus.res_last);
            end
            if (bus.res_valid === 1'b1 && exp_q.size() > 0) begin
                w = exp_q.pop_front();
                tests++;
                if (bus.res_data !== w || bus.res_id !== 1'b0) begin
                    fails++; $display("FAIL single_word c%0d: data=%0d id=%b, required %0d id 0", c, bus.res_data, bus.res_id, w);
                end
            end
            if (c == 4) begin
                tests++;
                if (bus.eng_data !== 8'd0) begin
                    fails++; $display("FAIL single_eng_data_wait: eng_data=%0d, required 0", bus.eng_data);
                end
            end
            if (c == 12) begin
                tests++;
                if (bus.res_data !== 11'd2 || bus.res_id !== 1'b0) begin
                    fails++; $display("FAIL single_hold: data=%0d id=%b, required 2 id 0", bus.res_data, bus.res_id);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL single_count: %0d words missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_contention();
        logic [RW-1:0] exp_q[$];
        logic          exp_id_q[$];
        logic          exp_last_q[$];
        logic [RW-1:0] ra[4];
        logic [RW-1:0] rb[6];
        logic [1:0]    prev_gnt;
        logic [RW-1:0] w;
        logic          wid, wl;
        int grants, g0, g1, lasts, busy_low, busy_bad, quiet_bad, c;
        do_reset();
        din0_vals[0] = 8'd3; din0_vals[1] = 8'd7;
        din1_vals[0] = 8'd10; din1_vals[1] = 8'd1; din1_vals[2] = 8'd4; din1_vals[3] = 8'd8;
        ra = '{11'd10, 11'd3, 11'd7, 11'd3};
        rb = '{11'd23, 11'd1, 11'd10, 11'd8, 11'd4, 11'd1};
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(ra[i]); exp_id_q.push_back(1'b0); exp_last_q.push_back(i == 3);
            end
            for (int i = 0; i < 6; i++) begin
                exp_q.push_back(rb[i]); exp_id_q.push_back(1'b1); exp_last_q.push_back(i == 5);
            end
        end
        grants = 0; g0 = 0; g1 = 0; lasts = 0; busy_low = 0; busy_bad = 0; quiet_bad = 0; c = 0;
        prev_gnt = 2'b00;
        bus.len0 = 3'd2; bus.len1 = 3'd4; bus.req = 2'b11;
        while (lasts < 4 && c < 200) begin
            tick();
            c++;
            if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin
                tests++;
                if (bus.gnt !== (((grants % 2) == 0) ? 2'b01 : 2'b10)) begin
                    fails++; $display("FAIL contention_order grant%0d: gnt=%b", grants, bus.gnt);
                end
                grants++;
                if (grants == 4) bus.req = 2'b00;
            end
            prev_gnt = bus.gnt;
            g0 += int'(bus.gnt[0]);
            g1 += int'(bus.gnt[1]);
            if (bus.busy === 1'b0) begin
                busy_low++;
                if (bus.res_last !== 1'b1) busy_bad++;
            end
            if (bus.res_valid !== 1'b1 && {bus.res_id, bus.res_last} !== 2'b00) quiet_bad++;
            if (bus.res_valid === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL contention_extra c%0d: data=%0d, required no word", c, bus.res_data);
                end else begin
                    w = exp_q.pop_front(); wid = exp_id_q.pop_front(); wl = exp_last_q.pop_front();
                    if ({bus.res_data, bus.res_id, bus.res_last} !== {w, wid, wl}) begin
                        fails++; $display("FAIL contention_word c%0d: data=%0d id=%b last=%b, required %0d id %b last %b", c, bus.res_data, bus.res_id, bus.res_last, w, wid, wl);
                    end
                end
                if (bus.res_last === 1'b1) lasts++;
            end
        end
        tests++;
        if (lasts != 4) begin fails++; $display("FAIL contention_batches: %0d completed, required 4", lasts); end
        tests++;
        if (g0 != 4 || g1 != 8) begin fails++; $display("FAIL contention_gnt_cycles: g0=%0d g1=%0d, required 4 and 8", g0, g1); end
        tests++;
        if (busy_low != 4 || busy_bad != 0) begin fails++; $display("FAIL contention_busy: low=%0d stray=%0d, required 4 and 0", busy_low, busy_bad); end
        tests++;
        if (quiet_bad != 0) begin fails++; $display("FAIL contention_quiet: %0d cycles with id/last set while invalid, required 0", quiet_bad); end
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL contention_count: %0d words missing, required 0", exp_q.size()); end
    endtask

    task automatic test_illegal_len();
        do_reset();
        din0_vals[0] = 8'd1; din1_vals[0] = 8'd2;
        // len1 = 0 rejected, pointer moves to 1
        bus.len0 = 3'd0; bus.len1 = 3'd0; bus.req = 2'b10;
        tick();
        bus.req = 2'b00;
        tests++;
        if (bus.err !== 2'b10 || bus.gnt !== 2'b00) begin
            fails++; $display("FAIL illegal_zero: err=%b gnt=%b, required 10 00", bus.err, bus.gnt);
        end
        tick();
        tests++;
        if (bus.err !== 2'b00 || bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL illegal_zero_after: err=%b gnt=%b busy=%b, required 00 00 0", bus.err, bus.gnt, bus.busy);
        end
        // pointer now favours requester 1
        bus.len0 = 3'd1; bus.len1 = 3'd1; bus.req = 2'b11;
        tick();
        bus.req = 2'b00;
        tests++;
        if (bus.gnt !== 2'b10) begin
            fails++; $display("FAIL illegal_ptr_flip: gnt=%b, required 10", bus.gnt);
        end
        wait_idle("illegal_flip_drain");
        // pointer back at 0 after requester 1's batch; len1 = 7 rejected
        bus.len1 = 3'd7; bus.req = 2'b10;
        tick();
        bus.req = 2'b00;
        tests++;
        if (bus.err !== 2'b10 || bus.gnt !== 2'b00) begin
            fails++; $display("FAIL illegal_seven: err=%b gnt=%b, required 10 00", bus.err, bus.gnt);
        end
        tick();
        tests++;
        if (bus.err !== 2'b00 || bus.gnt !== 2'b00) begin
            fails++; $display("FAIL illegal_seven_after: err=%b gnt=%b, required 00 00", bus.err, bus.gnt);
        end
        bus.len0 = 3'd1; bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        tests++;
        if (bus.gnt !== 2'b01 || bus.err !== 2'b00) begin
            fails++; $display("FAIL illegal_then_legal: gnt=%b err=%b, required 01 00", bus.gnt, bus.err);
        end
        wait_idle("illegal_legal_drain");
    endtask

    task automatic test_reset_mid_drain();
        int words, lasts, stray;
        logic [RW-1:0] w;
        do_reset();
        din0_vals[0] = 8'd5; din0_vals[1] = 8'd9; din0_vals[2] = 8'd2;
        bus.len0 = 3'd3; bus.req = 2'b01;
        words = 0; lasts = 0;
        for (int c = 1; c <= 20 && words < 3; c++) begin
            tick();
            if (c == 1) bus.req = 2'b00;
            if (bus.res_valid === 1'b1) words++;
            if (bus.res_last === 1'b1) lasts++;
        end
        tests++;
        if (words != 3 || lasts != 0) begin
            fails++; $display("FAIL rstmid_pre: words=%0d lasts=%0d, required 3 and 0", words, lasts);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (all_outs !== 30'd0) begin
            fails++; $display("FAIL rstmid_outputs: outputs=%h, required 0", all_outs);
        end
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.res_valid !== 1'b0 || bus.res_last !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        tests++;
        if (stray != 0) begin
            fails++; $display("FAIL rstmid_quiet: %0d active cycles, required 0", stray);
        end
        din0_vals[0] = 8'd42;
        bus.len0 = 3'd1; bus.req = 2'b01;
        words = 0; lasts = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) bus.req = 2'b00;
            if (bus.res_valid === 1'b1) begin
                words++;
                tests++;
                if (bus.res_data !== 11'd42 || bus.res_last !== (words == 3)) begin
                    fails++; $display("FAIL rstmid_word%0d: data=%0d last=%b, required 42 last %b", words, bus.res_data, bus.res_last, words == 3);
                end
                if (bus.res_last === 1'b1) lasts++;
            end
        end
        tests++;
        if (words != 3 || lasts != 1) begin
            fails++; $display("FAIL rstmid_after: words=%0d lasts=%0d, required 3 and 1", words, lasts);
        end
    endtask

    task automatic test_max_batch();
        logic [RW-1:0] exp_q[$];
        logic [RW-1:0] w;
        int g0, g1;
        do_reset();
        din0_vals = '{8'd4, 8'd200, 8'd17, 8'd99, 8'd0, 8'd63};
        din1_vals[0] = 8'd11; din1_vals[1] = 8'd22;
        exp_q = '{11'd383, 11'd0, 11'd200, 11'd99, 11'd63, 11'd17, 11'd4, 11'd0};
        g0 = 0; g1 = 0;
        bus.len0 = 3'd6; bus.len1 = 3'd2; bus.req = 2'b01;
        for (int c = 1; c <= 18; c++) begin
            tick();
            // from cycle 2 on requester 0 drops its request, requester 1 asks
            if (c == 1) bus.req = 2'b10;
            if (c <= 17) begin
                g0 += int'(bus.gnt[0]);
                g1 += int'(bus.gnt[1]);
            end
            tests++;
            if (bus.res_last !== (c == 17)) begin
                fails++; $display("FAIL max_last c%0d: res_last=%b", c, bus.res_last);
            end
            if (bus.res_valid === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL max_extra c%0d: data=%0d, required no word", c, bus.res_data);
                end else begin
                    w = exp_q.pop_front();
                    if (bus.res_data !== w || bus.res_id !== 1'b0) begin
                        fails++; $display("FAIL max_word c%0d: data=%0d id=%b, required %0d id 0", c, bus.res_data, bus.res_id, w);
                    end
                end
            end
            if (c == 18) begin
                tests++;
                if (bus.gnt !== 2'b10) begin
                    fails++; $display("FAIL max_next_grant: gnt=%b, required 10", bus.gnt);
                end
                bus.req = 2'b00;
            end
        end
        tests++;
        if (g0 != 6 || g1 != 0) begin
            fails++; $display("FAIL max_gnt_cycles: g0=%0d g1=%0d, required 6 and 0", g0, g1);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL max_count: %0d words missing, required 0", exp_q.size());
        end
        wait_idle("max_second_batch");
    endtask

`ifdef BOE_SCHED_PRIO_EN
    task automatic test_prio();
        logic [1:0] prev_gnt;
        int starts0, g1;
        do_reset();
        din0_vals[0] = 8'd7; din1_vals[0] = 8'd9;
        bus.len0 = 3'd1; bus.len1 = 3'd1; bus.req = 2'b11;
        prev_gnt = 2'b00; starts0 = 0; g1 = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (bus.gnt[0] === 1'b1 && prev_gnt[0] === 1'b0) starts0++;
            g1 += int'(bus.gnt[1]);
            prev_gnt = bus.gnt;
        end
        bus.req = 2'b00;
        tests++;
        if (starts0 != 5 || g1 != 0) begin
            fails++; $display("FAIL prio_grants: starts0=%0d g1=%0d, required 5 and 0", starts0, g1);
        end
        wait_idle("prio_drain");
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        bus.req = 2'b00; bus.len0 = 3'd0; bus.len1 = 3'd0;
        for (int i = 0; i < 6; i++) begin
            din0_vals[i] = 8'd0;
            din1_vals[i] = 8'd0;
        end
        test_reset();
        test_single_batch();
        test_contention();
        test_illegal_len();
        test_reset_mid_drain();
        test_max_batch();
`ifdef BOE_SCHED_PRIO_EN
        test_prio();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
